// File: rtl/epoch_rr_arbiter_if.sv
// rtl/epoch_rr_arbiter_if.sv - request/grant bundle between requesters (master) and the epoch arbiter (slave)
interface epoch_rr_arbiter_if #(
    parameter int NUM_REQ = 4
);
    localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] done;
    logic [NUM_REQ-1:0] gnt;
    logic [IDW-1:0]     gnt_id;
    logic               epoch_start;
    logic               busy;
    logic               timeout_pulse;

    modport master (
        output req, done,
        input  gnt, gnt_id, epoch_start, busy, timeout_pulse
    );

    modport slave (
        input  req, done,
        output gnt, gnt_id, epoch_start, busy, timeout_pulse
    );
endinterface

// File: rtl/epoch_rr_arbiter.sv
// rtl/epoch_rr_arbiter.sv - round-robin arbiter with grant epochs, hold timeout and forced idle gap; EPOCH_ARB_PRIO0_EN gives requester 0 fixed priority
module epoch_rr_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int MAX_HOLD = 8,
    parameter int GAP      = 1
) (
    input  logic              clk,
    input  logic              reset,
    epoch_rr_arbiter_if.slave bus
);
    localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int HCW = $clog2(MAX_HOLD + 1);
    localparam int GCW = $clog2(GAP + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GRANT,
        ST_GAP
    } state_t;

    state_t           state;
    logic [IDW-1:0]   rr_ptr;
    logic [HCW-1:0]   hold_cnt;
    logic [GCW-1:0]   gap_cnt;

    logic             any_req;
    logic [IDW-1:0]   winner;
    logic [IDW-1:0]   next_ptr;
    logic             owner_release;
    logic             start_epoch;

    // First set request searching upward from ptr, wrapping around.
    function automatic logic [IDW-1:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                               input logic [IDW-1:0]     ptr);
        logic [IDW-1:0] w;
        logic           found;
        int             c;
        w     = ptr;
        found = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            c = (int'(ptr) + i) % NUM_REQ;
            if (!found && r[IDW'(c)]) begin
                found = 1'b1;
                w     = IDW'(c);
            end
        end
        return w;
    endfunction

    // Arbitration winner, pointer advance and release/epoch decisions.
    always_comb begin
        any_req = |bus.req;
`ifdef EPOCH_ARB_PRIO0_EN
        if (bus.req[0]) begin
            winner = '0;
        end else begin
            winner = rr_pick(bus.req, rr_ptr);
        end
`else
        winner = rr_pick(bus.req, rr_ptr);
`endif
        next_ptr      = (bus.gnt_id == IDW'(NUM_REQ - 1)) ? '0 : bus.gnt_id + 1'b1;
        owner_release = bus.done[bus.gnt_id] || !bus.req[bus.gnt_id];
        start_epoch   = any_req &&
                        ((state == ST_IDLE) || ((state == ST_GAP) && (gap_cnt == GCW'(1))));
    end

    // Grant FSM; every output is a register updated here.
    always_ff @(posedge clk) begin
        if (reset) begin
            state             <= ST_IDLE;
            rr_ptr            <= '0;
            hold_cnt          <= '0;
            gap_cnt           <= '0;
            bus.gnt           <= '0;
            bus.gnt_id        <= '0;
            bus.epoch_start   <= 1'b0;
            bus.busy          <= 1'b0;
            bus.timeout_pulse <= 1'b0;
        end else begin
            bus.epoch_start   <= 1'b0;
            bus.timeout_pulse <= 1'b0;
            case (state)
                ST_IDLE: begin
                    state <= ST_IDLE;
                end
                ST_GRANT: begin
                    if (owner_release || (hold_cnt == HCW'(MAX_HOLD))) begin
                        // done/req-drop is checked first so it masks a coincident timeout
                        bus.timeout_pulse <= !owner_release;
                        bus.gnt           <= '0;
                        bus.busy          <= 1'b0;
                        rr_ptr            <= next_ptr;
                        gap_cnt           <= GCW'(GAP);
                        state             <= ST_GAP;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                ST_GAP: begin
                    gap_cnt <= gap_cnt - 1'b1;
                    if (gap_cnt == GCW'(1)) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
            // A new epoch overrides the IDLE/GAP bookkeeping above.
            if (start_epoch) begin
                state           <= ST_GRANT;
                bus.gnt         <= NUM_REQ'(1) << winner;
                bus.gnt_id      <= winner;
                bus.busy        <= 1'b1;
                bus.epoch_start <= 1'b1;
                hold_cnt        <= HCW'(1);
            end
        end
    end
endmodule
